// File: rtl/updown_counter_p.sv
// updown_counter_p
//   Parametrised synchronous up/down counter with configurable width and
//   modulus, wrap or saturate behaviour, parallel load, an enable prescaler,
//   registered wrap/clip pulses and a sticky overflow flag.
//
// Parameters
//   WIDTH    : counter width in bits (>= 1)
//   MAX_VAL  : highest count value, 1 .. 2**WIDTH-1
//   SATURATE : 0 = wrap at the bounds, 1 = clip at the bounds
//   PRESCALE : qualifying cycles per count step (>= 1)
//
// Ports
//   clk      in  : rising-edge clock
//   reset    in  : synchronous reset, active-low
//   enable   in  : count enable
//   up_en    in  : count-up request
//   down_en  in  : count-down request
//   load     in  : parallel load strobe (overrides counting)
//   load_val in  : value to load, clamped to MAX_VAL
//   clr_ovf  in  : clears the sticky overflow flag
//   count    out : registered count
//   wrap_up  out : one-cycle pulse when an up step passes MAX_VAL
//   wrap_dn  out : one-cycle pulse when a down step passes 0
//   at_max   out : count == MAX_VAL (combinational)
//   at_min   out : count == 0 (combinational)
//   ovf      out : sticky, set on any wrap or clip
module updown_counter_p #(
  parameter int WIDTH    = 4,
  parameter int MAX_VAL  = 2**WIDTH-1,
  parameter int SATURATE = 0,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             up_en,
  input  logic             down_en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] count,
  output logic             wrap_up,
  output logic             wrap_dn,
  output logic             at_max,
  output logic             at_min,
  output logic             ovf
);

  // A prescaler of 1 still keeps a 1-bit register that never leaves 0.
  localparam int PS_W      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int PS_LAST_I = PRESCALE - 1;
  localparam int MAX_I     = MAX_VAL;

  localparam logic [PS_W-1:0]  PS_LAST = PS_LAST_I[PS_W-1:0];
  localparam logic [WIDTH-1:0] MAX_C   = MAX_I[WIDTH-1:0];

  logic [WIDTH-1:0] count_q, count_d;
  logic [PS_W-1:0]  ps_q, ps_d;
  logic             wrap_up_q, wrap_up_d;
  logic             wrap_dn_q, wrap_dn_d;
  logic             ovf_q, ovf_d;
  logic             qualify;

  function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] v);
    return (v > MAX_C) ? MAX_C : v;
  endfunction

  // Up step modulo MAX_VAL+1. Anything at or above MAX_VAL is treated as the
  // top bound so an out-of-range count re-enters the legal range instead of
  // relying on 2**WIDTH rollover.
  function automatic logic [WIDTH-1:0] step_up(input logic [WIDTH-1:0] c);
    if (c >= MAX_C) begin
      if (SATURATE != 0) return MAX_C;
      return '0;
    end
    return c + 1'b1;
  endfunction

  // Down step modulo MAX_VAL+1; an out-of-range count drops back to MAX_VAL.
  function automatic logic [WIDTH-1:0] step_dn(input logic [WIDTH-1:0] c);
    if (c == '0) begin
      if (SATURATE != 0) return '0;
      return MAX_C;
    end
    if (c > MAX_C) return MAX_C;
    return c - 1'b1;
  endfunction

  // Conflicting or absent direction requests do not count as qualifying.
  assign qualify = enable & ~load & (up_en ^ down_en);

  always_comb begin
    count_d   = count_q;
    ps_d      = ps_q;
    wrap_up_d = 1'b0;
    wrap_dn_d = 1'b0;
    ovf_d     = ovf_q & ~clr_ovf;
    if (load) begin
      count_d = clamp_load(load_val);
      ps_d    = '0;
    end else if (qualify) begin
      if (ps_q == PS_LAST) begin
        ps_d = '0;
        if (up_en) begin
          count_d   = step_up(count_q);
          wrap_up_d = (count_q >= MAX_C);
        end else begin
          count_d   = step_dn(count_q);
          wrap_dn_d = (count_q == '0);
        end
        // A wrap/clip in the same cycle as clr_ovf leaves the flag set.
        if (wrap_up_d || wrap_dn_d) ovf_d = 1'b1;
      end else begin
        ps_d = ps_q + 1'b1;
      end
    end
  end

  // ---- register stage ----
  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q   <= '0;
      ps_q      <= '0;
      wrap_up_q <= 1'b0;
      wrap_dn_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      count_q   <= count_d;
      ps_q      <= ps_d;
      wrap_up_q <= wrap_up_d;
      wrap_dn_q <= wrap_dn_d;
      ovf_q     <= ovf_d;
    end
  end

  assign count   = count_q;
  assign wrap_up = wrap_up_q;
  assign wrap_dn = wrap_dn_q;
  assign ovf     = ovf_q;
  assign at_max  = (count_q == MAX_C);
  assign at_min  = (count_q == '0);

endmodule

// File: tb/tb_updown_counter_p.sv
// Testbench for updown_counter_p. Four instances with different
// configurations share one set of inputs:
//   0: WIDTH=4 MAX_VAL=9  SATURATE=0 PRESCALE=1
//   1: WIDTH=4 MAX_VAL=15 SATURATE=1 PRESCALE=1
//   2: WIDTH=4 MAX_VAL=9  SATURATE=0 PRESCALE=3
//   3: WIDTH=4 MAX_VAL=9  SATURATE=0 PRESCALE=4
module tb_updown_counter_p;

  logic       clk = 1'b0;
  logic       reset, enable, up_en, down_en, load, clr_ovf;
  logic [3:0] load_val;

  logic [3:0] cnt [4];
  logic       wu  [4];
  logic       wd  [4];
  logic       ov  [4];
  logic       amx [4];
  logic       amn [4];

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  updown_counter_p #(.WIDTH(4), .MAX_VAL(9), .SATURATE(0), .PRESCALE(1)) u_a (
    .clk(clk), .reset(reset), .enable(enable), .up_en(up_en), .down_en(down_en),
    .load(load), .load_val(load_val), .clr_ovf(clr_ovf), .count(cnt[0]),
    .wrap_up(wu[0]), .wrap_dn(wd[0]), .at_max(amx[0]), .at_min(amn[0]), .ovf(ov[0]));

  updown_counter_p #(.WIDTH(4), .MAX_VAL(15), .SATURATE(1), .PRESCALE(1)) u_b (
    .clk(clk), .reset(reset), .enable(enable), .up_en(up_en), .down_en(down_en),
    .load(load), .load_val(load_val), .clr_ovf(clr_ovf), .count(cnt[1]),
    .wrap_up(wu[1]), .wrap_dn(wd[1]), .at_max(amx[1]), .at_min(amn[1]), .ovf(ov[1]));

  updown_counter_p #(.WIDTH(4), .MAX_VAL(9), .SATURATE(0), .PRESCALE(3)) u_c (
    .clk(clk), .reset(reset), .enable(enable), .up_en(up_en), .down_en(down_en),
    .load(load), .load_val(load_val), .clr_ovf(clr_ovf), .count(cnt[2]),
    .wrap_up(wu[2]), .wrap_dn(wd[2]), .at_max(amx[2]), .at_min(amn[2]), .ovf(ov[2]));

  updown_counter_p #(.WIDTH(4), .MAX_VAL(9), .SATURATE(0), .PRESCALE(4)) u_d (
    .clk(clk), .reset(reset), .enable(enable), .up_en(up_en), .down_en(down_en),
    .load(load), .load_val(load_val), .clr_ovf(clr_ovf), .count(cnt[3]),
    .wrap_up(wu[3]), .wrap_dn(wd[3]), .at_max(amx[3]), .at_min(amn[3]), .ovf(ov[3]));

  // Reference model: configuration and state per instance, plain integers.
  int MAXV [4] = '{9, 15, 9, 9};
  int SATV [4] = '{0, 1, 0, 0};
  int PSV  [4] = '{1, 1, 3, 4};
  int mc   [4] = '{0, 0, 0, 0};
  int mp   [4] = '{0, 0, 0, 0};
  int mwu  [4] = '{0, 0, 0, 0};
  int mwd  [4] = '{0, 0, 0, 0};
  int movf [4] = '{0, 0, 0, 0};

  function automatic void model_step(int i);
    int m   = MAXV[i];
    int c   = mc[i];
    int p   = mp[i];
    int nwu = 0;
    int nwd = 0;
    int nov = (movf[i] != 0 && !clr_ovf) ? 1 : 0;
    if (!reset) begin
      c = 0; p = 0; nov = 0;
    end else if (load) begin
      c = (int'(load_val) > m) ? m : int'(load_val);
      p = 0;
    end else if (enable && (up_en != down_en)) begin
      p = (mp[i] + 1) % PSV[i];
      if (p == 0) begin
        if (up_en) begin
          if (mc[i] == m) begin nwu = 1; nov = 1; end
          c = (SATV[i] != 0 && mc[i] == m) ? m : (mc[i] + 1) % (m + 1);
        end else begin
          if (mc[i] == 0) begin nwd = 1; nov = 1; end
          c = (SATV[i] != 0 && mc[i] == 0) ? 0 : (mc[i] + m) % (m + 1);
        end
      end
    end
    mc[i] = c; mp[i] = p; mwu[i] = nwu; mwd[i] = nwd; movf[i] = nov;
  endfunction

  // Model advances with the inputs applied for this edge; outputs are
  // sampled 1 time unit after the edge.
  task automatic tick();
    for (int i = 0; i < 4; i++) model_step(i);
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic check_inst(input int i, input string tag, input int c, input int e_wu,
                            input int e_wd, input int e_ov, input int e_mx, input int e_mn);
    chk($sformatf("%s[%0d] count", tag, i),   32'(cnt[i]), c);
    chk($sformatf("%s[%0d] wrap_up", tag, i), 32'(wu[i]),  e_wu);
    chk($sformatf("%s[%0d] wrap_dn", tag, i), 32'(wd[i]),  e_wd);
    chk($sformatf("%s[%0d] ovf", tag, i),     32'(ov[i]),  e_ov);
    chk($sformatf("%s[%0d] at_max", tag, i),  32'(amx[i]), e_mx);
    chk($sformatf("%s[%0d] at_min", tag, i),  32'(amn[i]), e_mn);
  endtask

  task automatic idle();
    reset = 1'b1; enable = 1'b0; up_en = 1'b0; down_en = 1'b0;
    load = 1'b0; load_val = 4'd0; clr_ovf = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  // Directed vectors for instance 0 (MAX_VAL=9, wrap, PRESCALE=1).
  typedef struct {
    int rst, en, up, dn, ld, lv, clr;
    int cnt, wu, wd, ovf, amax, amin;
  } vec_t;
  vec_t tbl [$];

  function automatic void add_v(int rst, int en, int up, int dn, int ld, int lv, int clr,
                                int c, int e_wu, int e_wd, int e_ov, int e_mx, int e_mn);
    vec_t v;
    v.rst = rst; v.en = en; v.up = up; v.dn = dn; v.ld = ld; v.lv = lv; v.clr = clr;
    v.cnt = c; v.wu = e_wu; v.wd = e_wd; v.ovf = e_ov; v.amax = e_mx; v.amin = e_mn;
    tbl.push_back(v);
  endfunction

  initial begin
    int c;
    idle();

    // Reset, then 12 up steps: 1..9, 0, 1, 2 with the wrap at step 10.
    add_v(0,0,0,0,0,0,0,  0,0,0,0,0,1);
    for (int k = 1; k <= 12; k++) begin
      c = k % 10;
      add_v(1,1,1,0,0,0,0, c, (k == 10) ? 1 : 0, 0, (k >= 10) ? 1 : 0,
            (c == 9) ? 1 : 0, (c == 0) ? 1 : 0);
    end
    add_v(1,0,0,0,1,0,0,  0,0,0,1,0,1);   // load 0, ovf still set
    add_v(1,1,0,1,0,0,0,  9,0,1,1,1,0);   // down wrap 0 -> 9
    add_v(1,0,0,0,0,0,1,  9,0,0,0,1,0);   // clr_ovf
    add_v(1,0,0,0,0,0,0,  9,0,0,0,1,0);   // hold
    add_v(1,1,1,1,0,0,0,  9,0,0,0,1,0);   // conflicting directions hold
    add_v(1,0,0,0,1,12,0, 9,0,0,0,1,0);   // load 12 clamps to 9, no ovf
    add_v(1,1,1,0,1,3,0,  3,0,0,0,0,0);   // load beats enable/up
    add_v(1,1,0,0,0,0,0,  3,0,0,0,0,0);   // no direction holds
    add_v(1,0,0,0,1,9,0,  9,0,0,0,1,0);   // load 9
    add_v(1,1,1,0,0,0,1,  0,1,0,1,0,1);   // wrap with clr_ovf: set wins
    add_v(1,0,0,0,0,0,1,  0,0,0,0,0,1);   // clr_ovf

    foreach (tbl[n]) begin
      reset    = (tbl[n].rst != 0);
      enable   = (tbl[n].en  != 0);
      up_en    = (tbl[n].up  != 0);
      down_en  = (tbl[n].dn  != 0);
      load     = (tbl[n].ld  != 0);
      load_val = tbl[n].lv[3:0];
      clr_ovf  = (tbl[n].clr != 0);
      tick();
      check_inst(0, $sformatf("vec%0d", n), tbl[n].cnt, tbl[n].wu, tbl[n].wd,
                 tbl[n].ovf, tbl[n].amax, tbl[n].amin);
    end

    // Saturate mode (instance 1): load 14, three ups, twenty downs.
    do_reset();
    load = 1'b1; load_val = 4'd14;
    tick();
    load = 1'b0;
    check_inst(1, "sat_load", 14, 0, 0, 0, 0, 0);
    enable = 1'b1; up_en = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      tick();
      check_inst(1, $sformatf("sat_up%0d", k), 15, (k >= 2) ? 1 : 0, 0, (k >= 2) ? 1 : 0, 1, 0);
    end
    up_en = 1'b0; down_en = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      c = (k <= 15) ? 15 - k : 0;
      check_inst(1, $sformatf("sat_dn%0d", k), c, 0, (k > 15) ? 1 : 0, 1, 0, (c == 0) ? 1 : 0);
    end

    // Prescaler 3 (instance 2): 2 qualifying, 2 disabled, 5 qualifying.
    do_reset();
    enable = 1'b1; up_en = 1'b1;
    tick(); tick();
    check_inst(2, "ps3_q2", 0, 0, 0, 0, 0, 1);
    enable = 1'b0;
    tick(); tick();
    check_inst(2, "ps3_off", 0, 0, 0, 0, 0, 1);
    enable = 1'b1;
    tick();
    check_inst(2, "ps3_q3", 1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) tick();
    check_inst(2, "ps3_q7", 2, 0, 0, 0, 0, 0);

    // Prescaler 4 (instance 3): set ovf, load 5, partial interval, reset.
    do_reset();
    enable = 1'b1; down_en = 1'b1;
    for (int k = 0; k < 3; k++) tick();
    check_inst(3, "ps4_dn3", 0, 0, 0, 0, 0, 1);
    tick();
    check_inst(3, "ps4_dn4", 9, 0, 1, 1, 1, 0);
    idle();
    load = 1'b1; load_val = 4'd5;
    tick();
    load = 1'b0; enable = 1'b1; up_en = 1'b1;
    tick(); tick();
    check_inst(3, "ps4_part", 5, 0, 0, 1, 0, 0);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check_inst(3, "ps4_rst", 0, 0, 0, 0, 0, 1);
    for (int k = 0; k < 3; k++) tick();
    check_inst(3, "ps4_q3", 0, 0, 0, 0, 0, 1);
    tick();
    check_inst(3, "ps4_q4", 1, 0, 0, 0, 0, 0);

    // Random stimulus against the reference model, all instances.
    do_reset();
    for (int n = 0; n < 600; n++) begin
      reset    = ($urandom_range(0, 49) != 0);
      load     = ($urandom_range(0, 11) == 0);
      load_val = 4'($urandom);
      enable   = ($urandom_range(0, 3) != 0);
      up_en    = 1'($urandom);
      down_en  = 1'($urandom);
      clr_ovf  = ($urandom_range(0, 7) == 0);
      tick();
      for (int i = 0; i < 4; i++)
        check_inst(i, $sformatf("rnd%0d", n), mc[i], mwu[i], mwd[i], movf[i],
                   (mc[i] == MAXV[i]) ? 1 : 0, (mc[i] == 0) ? 1 : 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
